// File: rtl/luma_filter_8tap_pkg.sv
// Shared constants, types and FSM encoding for the HEVC 8-tap luma filter.
package hevc_luma_pkg;

  localparam int TAPS         = 8;
  localparam int COEF_WIDTH   = 9;
  localparam int SAMPLE_WIDTH = 8;
  localparam int CNT_W        = $clog2(TAPS);

  typedef logic signed [8:0]  coef_t;
  typedef logic        [7:0]  sample_t;
  typedef logic signed [15:0] acc_t;

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, WRITE} state_t;

  localparam int ROUND_OFFSET = 32;
  localparam int ROUND_SHIFT  = 6;

endpackage

// File: rtl/luma_filter_8tap_if.sv
// Multi-flux FIFO read/write interfaces: one data bus, per-flux status and strobes.
interface read_interface #(
  parameter int DW   = 10,
  parameter int FLUX = 2
);
  logic [DW-1:0]   dout;
  logic [FLUX-1:0] empty;
  logic [FLUX-1:0] read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int DW   = 17,
  parameter int FLUX = 2
);
  logic [DW-1:0]   din;
  logic [FLUX-1:0] full;
  logic            write;

  modport actor (output din, input full, output write);
  modport fifo  (input din, output full, input write);
endinterface

// File: rtl/luma_filter_8tap_mac.sv
// Coefficient register file, signed MAC and optional round/clip (LUMA_FILTER_ROUND_EN).
module luma_mac
  import hevc_luma_pkg::*;
#(
  parameter int COEF_WIDTH   = 9,
  parameter int SAMPLE_WIDTH = 8,
  parameter int ACC_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [TAPS*COEF_WIDTH-1:0]    coef_flat,
  input  logic                          acc_en,
  input  logic [CNT_W-1:0]              tap,
  input  logic [SAMPLE_WIDTH-1:0]       sample,
  output logic signed [ACC_WIDTH-1:0]   result
);

  localparam int PROD_W = COEF_WIDTH + SAMPLE_WIDTH + 1;

  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
  logic signed [PROD_W-1:0]     coef_x, samp_x, prod;
  logic signed [ACC_WIDTH-1:0]  prod_acc, acc;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= coef_flat[i*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end

  // Sample is unsigned pixel data: zero-extend before the signed multiply.
  assign coef_x   = PROD_W'(coef_q[tap]);
  assign samp_x   = PROD_W'($signed({1'b0, sample}));
  assign prod     = coef_x * samp_x;
  assign prod_acc = ACC_WIDTH'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + prod_acc;
    end
  end

`ifdef LUMA_FILTER_ROUND_EN
  localparam int PIX_MAX = (1 << SAMPLE_WIDTH) - 1;

  function automatic logic signed [ACC_WIDTH-1:0] round_clip(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] biased, shifted;
    biased  = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(ROUND_OFFSET);
    shifted = biased >>> ROUND_SHIFT;
    if (shifted < 0)            return '0;
    else if (shifted > PIX_MAX) return ACC_WIDTH'(PIX_MAX);
    else                        return shifted[ACC_WIDTH-1:0];
  endfunction

  assign result = round_clip(acc);
`else
  assign result = acc;
`endif

endmodule

// File: rtl/luma_filter_8tap.sv
// 8-tap HEVC luma filter: per-flux job FSM and FIFO handshakes around luma_mac.
// Build with LUMA_FILTER_ROUND_EN for (acc+32)>>>6 clipped to 0..255 output.
module luma_filter_8tap
  import hevc_luma_pkg::*;
#(
  parameter int FLUX         = 2,
  parameter int COEF_WIDTH   = 9,
  parameter int SAMPLE_WIDTH = 8,
  parameter int ACC_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  read_interface.actor   read_port_c0,
  read_interface.actor   read_port_c1,
  read_interface.actor   read_port_c2,
  read_interface.actor   read_port_c3,
  read_interface.actor   read_port_c4,
  read_interface.actor   read_port_c5,
  read_interface.actor   read_port_c6,
  read_interface.actor   read_port_c7,
  read_interface.actor   read_port_sample,
  write_interface.actor  write_port_result
);

  localparam int TAG_WIDTH = $clog2(FLUX);

  state_t                      state, state_nxt;
  logic [TAG_WIDTH-1:0]        lock, pick;
  logic [CNT_W-1:0]            cnt;
  logic [FLUX-1:0]             ready, lock_oh, coef_strb, samp_strb;
  logic                        found, coef_rd, samp_rd, wr_en;
  logic [TAPS*COEF_WIDTH-1:0]  coef_flat;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        unused_tags;

  assign ready = ~(read_port_c0.empty | read_port_c1.empty | read_port_c2.empty |
                   read_port_c3.empty | read_port_c4.empty | read_port_c5.empty |
                   read_port_c6.empty | read_port_c7.empty | read_port_sample.empty |
                   write_port_result.full);

  // Lowest ready flux wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        pick  = TAG_WIDTH'(i);
      end
    end
  end

  always_comb begin
    lock_oh       = '0;
    lock_oh[lock] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    coef_rd   = 1'b0;
    samp_rd   = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE:  if (found) state_nxt = LOAD;
      LOAD: begin
        coef_rd   = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        if (!read_port_sample.empty[lock]) begin
          samp_rd = 1'b1;
          if (cnt == CNT_W'(TAPS - 1)) state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!write_port_result.full[lock]) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lock  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) lock <= pick;
      if (coef_rd)      cnt <= '0;
      else if (samp_rd) cnt <= cnt + 1'b1;
    end
  end

  assign coef_strb = coef_rd ? lock_oh : '0;
  assign samp_strb = samp_rd ? lock_oh : '0;

  assign read_port_c0.read     = coef_strb;
  assign read_port_c1.read     = coef_strb;
  assign read_port_c2.read     = coef_strb;
  assign read_port_c3.read     = coef_strb;
  assign read_port_c4.read     = coef_strb;
  assign read_port_c5.read     = coef_strb;
  assign read_port_c6.read     = coef_strb;
  assign read_port_c7.read     = coef_strb;
  assign read_port_sample.read = samp_strb;

  assign write_port_result.write = wr_en;
  assign write_port_result.din   = (state == WRITE) ? {lock, result} : '0;

  assign coef_flat = {read_port_c7.dout[COEF_WIDTH-1:0], read_port_c6.dout[COEF_WIDTH-1:0],
                      read_port_c5.dout[COEF_WIDTH-1:0], read_port_c4.dout[COEF_WIDTH-1:0],
                      read_port_c3.dout[COEF_WIDTH-1:0], read_port_c2.dout[COEF_WIDTH-1:0],
                      read_port_c1.dout[COEF_WIDTH-1:0], read_port_c0.dout[COEF_WIDTH-1:0]};

  // Incoming tags are ignored; the locked flux is the authoritative tag.
  assign unused_tags = ^{read_port_c0.dout[COEF_WIDTH +: TAG_WIDTH], read_port_c1.dout[COEF_WIDTH +: TAG_WIDTH],
                         read_port_c2.dout[COEF_WIDTH +: TAG_WIDTH], read_port_c3.dout[COEF_WIDTH +: TAG_WIDTH],
                         read_port_c4.dout[COEF_WIDTH +: TAG_WIDTH], read_port_c5.dout[COEF_WIDTH +: TAG_WIDTH],
                         read_port_c6.dout[COEF_WIDTH +: TAG_WIDTH], read_port_c7.dout[COEF_WIDTH +: TAG_WIDTH],
                         read_port_sample.dout[SAMPLE_WIDTH +: TAG_WIDTH]};

  luma_mac #(
    .COEF_WIDTH   (COEF_WIDTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .load      (coef_rd),
    .coef_flat (coef_flat),
    .acc_en    (samp_rd),
    .tap       (cnt),
    .sample    (read_port_sample.dout[SAMPLE_WIDTH-1:0]),
    .result    (result)
  );

endmodule

// File: tb/tb_luma_filter_8tap.sv
// Directed bench for luma_filter_8tap: FIFO models per port/flux, job-level model, protocol monitor.
module tb_luma_filter_8tap;

  localparam int FLUX  = 2;
  localparam int CW    = 9;
  localparam int SW    = 8;
  localparam int AW    = 16;
  localparam int TW    = 1;
  localparam int DEPTH = 64;

`ifdef LUMA_FILTER_ROUND_EN
  localparam int E_ID = 13, E_HP = 255, E_QP = 91, E_NEG = 0;
`else
  localparam int E_ID = 832, E_HP = 16320, E_QP = 5800, E_NEG = -12800;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_interface  #(.DW(TW+CW), .FLUX(FLUX)) c_if [8] ();
  read_interface  #(.DW(TW+SW), .FLUX(FLUX)) s_if ();
  write_interface #(.DW(TW+AW), .FLUX(FLUX)) w_if ();

  luma_filter_8tap dut (
    .clk               (clk),
    .rst               (rst),
    .read_port_c0      (c_if[0]),
    .read_port_c1      (c_if[1]),
    .read_port_c2      (c_if[2]),
    .read_port_c3      (c_if[3]),
    .read_port_c4      (c_if[4]),
    .read_port_c5      (c_if[5]),
    .read_port_c6      (c_if[6]),
    .read_port_c7      (c_if[7]),
    .read_port_sample  (s_if),
    .write_port_result (w_if)
  );

  // FIFO models: ports 0..7 are coefficients, port 8 is samples.
  int              mem    [9][FLUX][DEPTH];
  int              wr_ptr [9][FLUX];
  int              rd_ptr [9][FLUX];
  logic [FLUX-1:0] rd_v   [9];
  logic [FLUX-1:0] emp_v  [9];
  logic [TW+CW-1:0] cdout [8];
  logic [TW+SW-1:0] sdout;
  logic [FLUX-1:0] full_v;
  int              cyc = 0;

  for (genvar p = 0; p < 8; p++) begin : g_cp
    assign rd_v[p]        = c_if[p].read;
    assign c_if[p].empty  = emp_v[p];
    assign c_if[p].dout   = cdout[p];
  end
  assign rd_v[8]    = s_if.read;
  assign s_if.empty = emp_v[8];
  assign s_if.dout  = sdout;
  assign w_if.full  = full_v;

  always_comb begin
    for (int p = 0; p < 9; p++)
      for (int f = 0; f < FLUX; f++)
        emp_v[p][f] = (rd_ptr[p][f] == wr_ptr[p][f]);
  end

  always_comb begin
    sdout = '0;
    for (int p = 0; p < 8; p++) begin
      cdout[p] = '0;
      for (int f = 0; f < FLUX; f++)
        if (rd_v[p][f]) cdout[p] = {TW'(f), CW'(mem[p][f][rd_ptr[p][f] % DEPTH])};
    end
    for (int f = 0; f < FLUX; f++)
      if (rd_v[8][f]) sdout = {TW'(f), SW'(mem[8][f][rd_ptr[8][f] % DEPTH])};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else
      for (int p = 0; p < 9; p++)
        for (int f = 0; f < FLUX; f++)
          if (rd_v[p][f]) rd_ptr[p][f] <= rd_ptr[p][f] + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nmis = 0;
  int exp_q [FLUX][$];

  task automatic check(input string name, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int model(input int c[8], input int s[8]);
    int r = 0;
    for (int i = 0; i < 8; i++) r += c[i] * s[i];
`ifdef LUMA_FILTER_ROUND_EN
    r = (r + 32) >>> 6;
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
`endif
    return r;
  endfunction

  // Monitor: job tracking and result check against the model queue.
  bit active = 0;
  int cur = 0, nsamp = 0, n_writes = 0, load_cyc = 0, write_cyc = 0, last_data = 0, last_tag = 0;

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      logic any_c;
      int   sf;
      any_c = 1'b0;
      for (int p = 0; p < 8; p++) any_c |= |rd_v[p];
      if (any_c) begin
        for (int p = 1; p < 8; p++) check("coef_strobe_align", int'(rd_v[p]), int'(rd_v[0]));
        check("coef_strobe_onehot", int'($onehot(rd_v[0])), 1);
        check("coef_read_nonempty", int'(|(rd_v[0] & emp_v[0])), 0);
        check("coef_read_while_busy", int'(active), 0);
        active   = 1;
        nsamp    = 0;
        load_cyc = cyc;
        cur      = rd_v[0][1] ? 1 : 0;
      end
      if (|rd_v[8]) begin
        sf = rd_v[8][1] ? 1 : 0;
        check("sample_strobe_onehot", int'($onehot(rd_v[8])), 1);
        check("sample_read_nonempty", int'(|(rd_v[8] & emp_v[8])), 0);
        check("sample_read_active", int'(active), 1);
        check("sample_flux_locked", sf, cur);
        nsamp++;
      end
      if (w_if.write) begin
        last_tag  = int'(w_if.din[AW]);
        last_data = int'($signed(w_if.din[AW-1:0]));
        check("write_not_full", int'(full_v[last_tag]), 0);
        check("write_active", int'(active), 1);
        check("write_tag", last_tag, cur);
        check("write_after_8_samples", nsamp, 8);
        if (exp_q[last_tag].size() == 0) check("unexpected_write", 1, 0);
        else check("result_vs_model", last_data, exp_q[last_tag].pop_front());
        active    = 0;
        write_cyc = cyc;
        n_writes++;
      end
    end
  end

  int ID_C [8] = '{0, 0, 0, 64, 0, 0, 0, 0};
  int ID_S [8] = '{10, 11, 12, 13, 14, 15, 16, 17};
  int HP_C [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  int HP_S [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
  int QP_C [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  int QP_S [8] = '{0, 0, 0, 100, 0, 0, 0, 0};
  int NG_C [8] = '{0, 0, 0, -64, 0, 0, 0, 0};
  int NG_S [8] = '{0, 0, 0, 200, 0, 0, 0, 0};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_coefs(input int f, input int c[8]);
    for (int p = 0; p < 8; p++) begin
      mem[p][f][wr_ptr[p][f] % DEPTH] = c[p];
      wr_ptr[p][f]++;
    end
  endtask

  task automatic push_samples(input int f, input int s[8], input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mem[8][f][wr_ptr[8][f] % DEPTH] = s[i];
      wr_ptr[8][f]++;
    end
  endtask

  task automatic job(input int f, input int c[8], input int s[8]);
    push_coefs(f, c);
    push_samples(f, s, 0, 7);
    exp_q[f].push_back(model(c, s));
  endtask

  task automatic wait_writes(input int target);
    int t = 0;
    while (n_writes < target && t < 300) begin
      step();
      t++;
    end
    check("write_wait_bound", n_writes, target);
  endtask

  task automatic check_idle_outputs(input string name);
    logic any_r;
    any_r = 1'b0;
    for (int p = 0; p < 9; p++) any_r |= |rd_v[p];
    check({name, "_reads"}, int'(any_r), 0);
    check({name, "_write"}, int'(w_if.write), 0);
    check({name, "_din"}, int'(w_if.din), 0);
  endtask

  initial begin
    int w0, t, nw;
    rst    = 1'b1;
    full_v = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) step();
    check_idle_outputs("idle_empty");

    // Identity on flux 0.
    job(0, ID_C, ID_S);
    wait_writes(1);
    check("identity_data", last_data, E_ID);
    check("identity_tag", last_tag, 0);
    check("identity_latency", write_cyc - load_cyc, 9);

    // Half-pel, all-255 samples.
    job(0, HP_C, HP_S);
    wait_writes(2);
    check("halfpel_data", last_data, E_HP);

    // Quarter-pel on flux 1.
    job(1, QP_C, QP_S);
    wait_writes(3);
    check("qpel_data", last_data, E_QP);
    check("qpel_tag", last_tag, 1);

    // Both fluxes ready at once: flux 0 first, flux 1 loads two cycles after.
    job(1, ID_C, ID_S);
    job(0, HP_C, HP_S);
    wait_writes(4);
    check("arb_first_tag", last_tag, 0);
    check("arb_first_data", last_data, E_HP);
    w0 = write_cyc;
    wait_writes(5);
    check("arb_second_tag", last_tag, 1);
    check("arb_second_data", last_data, E_ID);
    check("arb_second_load_gap", load_cyc - w0, 2);

    // Sample FIFO runs dry for 3 cycles before tap 4.
    push_coefs(0, ID_C);
    push_samples(0, ID_S, 0, 3);
    exp_q[0].push_back(model(ID_C, ID_S));
    t = 0;
    while (!(active && nsamp == 4) && t < 100) begin step(); t++; end
    check("stall_reached_tap4", int'(t < 100), 1);
    repeat (3) step();
    push_samples(0, ID_S, 4, 7);
    wait_writes(6);
    check("stall_data", last_data, E_ID);
    check("stall_latency", write_cyc - load_cyc, 12);

    // Output full for 5 WRITE cycles; flux 1 becomes ready mid-job.
    job(0, QP_C, QP_S);
    t = 0;
    while (!active && t < 100) begin step(); t++; end
    check("full_job_started", int'(active), 1);
    full_v[0] = 1'b1;
    job(1, ID_C, ID_S);
    t = 0;
    while (cyc < load_cyc + 14 && t < 100) begin step(); t++; end
    full_v[0] = 1'b0;
    wait_writes(7);
    check("full_data", last_data, E_QP);
    check("full_latency", write_cyc - load_cyc, 14);
    w0 = write_cyc;
    wait_writes(8);
    check("after_full_tag", last_tag, 1);
    check("after_full_data", last_data, E_ID);
    check("after_full_load_gap", load_cyc - w0, 2);

    // Negative accumulation.
    job(0, NG_C, NG_S);
    wait_writes(9);
    check("negative_data", last_data, E_NEG);

    // Reset while accumulating tap 5.
    job(0, HP_C, ID_S);
    t = 0;
    while (!(active && nsamp == 5) && t < 100) begin step(); t++; end
    check("reset_reached_tap5", int'(t < 100), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midjob_reset");
    exp_q[0].delete();
    nw = n_writes;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    check("no_write_after_abort", n_writes, nw);
    job(0, ID_C, ID_S);
    wait_writes(nw + 1);
    check("post_reset_data", last_data, E_ID);
    check("post_reset_tag", last_tag, 0);
    check("post_reset_latency", write_cyc - load_cyc, 9);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/luma_filter_8tap.md
Name: luma_filter_8tap

Overview:
- Consumer at the far end of the luma coefficient streams c0..c7 in the HEVC interpolation dataflow.
- Per job, it reads one coefficient token from each of the 8 coefficient FIFOs and 8 reference samples, serially, from a sample FIFO.
- It computes the signed 8-tap dot product and writes one tagged result token.
- Multi-flux: every token carries a flux tag, and a job stays on one flux from start to finish.

Parameters:
- FLUX, 2, number of interleaved data fluxes; localparam TAG_WIDTH = $clog2(FLUX).
- COEF_WIDTH, 9, signed coefficient width.
- SAMPLE_WIDTH, 8, unsigned sample width.
- ACC_WIDTH, 16, signed accumulator and result data width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_port_c0 .. read_port_c7  read_interface.actor  dout TAG_WIDTH+COEF_WIDTH, empty/read FLUX  coefficient taps 0..7.
- read_port_sample  read_interface.actor  dout TAG_WIDTH+SAMPLE_WIDTH, empty/read FLUX  samples, tap order 0..7.
- write_port_result  write_interface.actor  din TAG_WIDTH+ACC_WIDTH, full FLUX, write 1  filtered result.

Behaviour:
- Token format: dout and din are {tag, data}, with tag in the MSBs.
- Strobe rules:
  - read[i] pulses for exactly one cycle per token consumed, and only on the locked flux.
  - At most one read bit is high per port per cycle.
  - write is high for one cycle per result.
- Reset (asynchronous): state=IDLE, tap counter=0, accumulator=0, locked flux=0, every read[*]=0, write=0, din=0.
- A reset during any state aborts the job. Tokens already consumed are discarded and no result is written.
- FSM states:
  - IDLE: each cycle, scan flux 0..FLUX-1 and lock the lowest i where all nine read ports have empty[i]==0 and write_port_result.full[i]==0. Then go to LOAD. If no flux qualifies, stay in IDLE.
  - LOAD: assert read[lock] on c0..c7 in the same cycle, register the 8 coefficients, clear the accumulator, set counter=0, go to ACCUM.
  - ACCUM: when read_port_sample.empty[lock]==0, assert read[lock] and add coef[counter]*sample to the accumulator. Products are COEF_WIDTH+SAMPLE_WIDTH+1 bits signed, with the sample zero-extended. Increment the counter.
    - When the sample port is empty, stall: no read, counter and accumulator hold.
    - After the tap-7 sample is accumulated, go to WRITE.
  - WRITE: drive din={lock, result}. Assert write only when full[lock]==0; otherwise hold in WRITE with write=0. On the write cycle, return to IDLE.
- Arithmetic: accumulate sign-extended to ACC_WIDTH. Valid HEVC luma sets fit in 16 bits; no saturation in raw mode.
- Latency: minimum 11 cycles from IDLE lock to the write pulse (1 IDLE + 1 LOAD + 8 ACCUM + 1 WRITE). Throughput is one job per 11 cycles.
- Flux lock holds for the whole job; a flux becoming ready mid-job is ignored until IDLE.
- Output full during WRITE: wait with no reads on any port.
- The coefficient tag field is ignored; the lock value is used as the tag.

Optional Feature:
- Macro: LUMA_FILTER_ROUND_EN.
- When defined, WRITE emits (acc + 32) >>> 6, clipped to 0..255 and zero-extended to ACC_WIDTH.
- When undefined, WRITE emits the raw accumulator.
- Timing and handshakes are identical in both modes.

Decomposition:
- Package hevc_luma_pkg holds:
  - the TAPS=8, COEF_WIDTH and SAMPLE_WIDTH constants;
  - typedefs coef_t (signed [8:0]), sample_t ([7:0]) and acc_t (signed [15:0]);
  - the state enum {IDLE, LOAD, ACCUM, WRITE};
  - the round constants 32 and 6.
- Sub-module luma_mac holds the coefficient register file, the multiplier, the accumulator and the optional round/clip. The top keeps the FSM and FIFO handshakes.

Test Plan:
- Identity: coeffs (0,0,0,64,0,0,0,0), samples 10..17 on flux 0 -> one write, din={0,832}; rounded mode gives 13.
- Half-pel: coeffs (-1,4,-11,40,40,-11,4,-1), all samples 255 -> din data 16320; rounded mode gives 255.
- Quarter-pel: coeffs (-1,4,-10,58,17,-5,1,0), samples (0,0,0,100,0,0,0,0) on flux 1 -> din={1,5800}; rounded mode gives 91.
- Arbitration: fluxes 0 and 1 both ready -> flux 0 job first; flux 1 starts in the cycle after the flux-0 write; no read strobe is ever high on a non-locked flux.
- Stall: sample empty for 3 cycles before tap 4 -> no reads, counter holds, same result, latency 14. Output full for 5 cycles in WRITE -> write delayed 5 cycles, no new coefficient reads.
- Reset mid-ACCUM at tap 5 -> all strobes 0 immediately, no write; the next full job produces a correct result.
